// File: rtl/activation_pkg.sv
// Shared types and the activation function used by every lane of activation_array.
// The function works on a wide signed value so one definition serves any DATA_WIDTH below 32.
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

    localparam int ACT_CALC_WIDTH = 32;

    typedef logic signed [ACT_CALC_WIDTH-1:0] act_calc_t;

    // Every mode yields a value between min(x, 0) and max(x, 0), so truncating the result
    // back to the lane width is always exact.
    function automatic act_calc_t apply_act(input act_calc_t   x,
                                            input act_mode_e   mode,
                                            input act_calc_t   clip,
                                            input int unsigned shift);
        act_calc_t y;
        y = x;
        case (mode)
            ACT_BYPASS: y = x;
            ACT_RELU:   y = (x < 0) ? '0 : x;
            ACT_LEAKY:  y = (x < 0) ? (x >>> shift) : x;
            ACT_CLIP: begin
                if (clip <= 0 || x < 0) begin
                    y = '0;
                end else if (x > clip) begin
                    y = clip;
                end else begin
                    y = x;
                end
            end
            default:    y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/activation_lane.sv
// One activation lane: applies the activation at input transfer, then holds up to two
// beats (output register plus skid register) with a registered ready.
module activation_lane
    import activation_pkg::*;
#(
    parameter int          DATA_WIDTH    = 8,
    parameter int          ADDRESS_WIDTH = 10,
    parameter int unsigned LEAKY_SHIFT   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lane_en,
    input  act_mode_e                mode,
    input  logic [DATA_WIDTH-1:0]    clip,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic                     acc_last,
    input  logic [DATA_WIDTH-1:0]    acc_result,
    input  logic [ADDRESS_WIDTH-1:0] acc_result_address,
    output logic                     act_valid,
    input  logic                     pool_ready,
    output logic                     act_last,
    output logic [DATA_WIDTH-1:0]    act_result,
    output logic [ADDRESS_WIDTH-1:0] act_result_address
);

    localparam int PAD = ACT_CALC_WIDTH - DATA_WIDTH;

    act_calc_t               x_ext;
    act_calc_t               clip_ext;
    act_calc_t               y_ext;
    logic [PAD-1:0]          y_hi_unused;
    logic [DATA_WIDTH-1:0]   y_data;

    assign x_ext    = {{PAD{acc_result[DATA_WIDTH-1]}}, acc_result};
    assign clip_ext = {{PAD{clip[DATA_WIDTH-1]}}, clip};
    assign y_ext    = apply_act(x_ext, mode, clip_ext, LEAKY_SHIFT);
    assign {y_hi_unused, y_data} = y_ext;

    logic                     out_valid_reg;
    logic                     out_last_reg;
    logic [DATA_WIDTH-1:0]    out_data_reg;
    logic [ADDRESS_WIDTH-1:0] out_addr_reg;
    logic                     skid_valid_reg;
    logic                     skid_last_reg;
    logic [DATA_WIDTH-1:0]    skid_data_reg;
    logic [ADDRESS_WIDTH-1:0] skid_addr_reg;

    logic in_fire;
    logic load_out;

    assign in_fire  = acc_valid && !skid_valid_reg;
    assign load_out = !out_valid_reg || pool_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            out_addr_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_addr_reg  <= '0;
        end else if (!lane_en) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (load_out) begin
            // Skid contents take priority; ready was low, so no new beat competes with them.
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_last_reg   <= skid_last_reg;
                out_data_reg   <= skid_data_reg;
                out_addr_reg   <= skid_addr_reg;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= in_fire;
                if (in_fire) begin
                    out_last_reg <= acc_last;
                    out_data_reg <= y_data;
                    out_addr_reg <= acc_result_address;
                end
            end
        end else if (in_fire) begin
            skid_valid_reg <= 1'b1;
            skid_last_reg  <= acc_last;
            skid_data_reg  <= y_data;
            skid_addr_reg  <= acc_result_address;
        end
    end

    assign acc_ready          = !lane_en || !skid_valid_reg;
    assign act_valid          = lane_en && out_valid_reg;
    assign act_last           = out_last_reg;
    assign act_result         = out_data_reg;
    assign act_result_address = out_addr_reg;

endmodule

// File: rtl/activation_array.sv
// Activation stage for SA_LANES addressed lanes plus FC_LANES address-less lanes, with
// frame-completion tracking across all enabled lanes.
module activation_array
    import activation_pkg::*;
#(
    parameter int          SA_LANES      = 16,
    parameter int          FC_LANES      = 1,
    parameter int          DATA_WIDTH    = 8,
    parameter int          ADDRESS_WIDTH = 10,
    parameter int unsigned LEAKY_SHIFT   = 3,
    localparam int         LANES         = SA_LANES + FC_LANES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  act_mode_e                mode_i,
    input  logic [DATA_WIDTH-1:0]    clip_i,
    input  logic [LANES-1:0]         lane_en_i,
    input  logic                     acc_valid_i          [LANES],
    output logic                     acc_ready_o          [LANES],
    input  logic                     acc_last_i           [LANES],
    input  logic [DATA_WIDTH-1:0]    acc_result_i         [LANES],
    input  logic [ADDRESS_WIDTH-1:0] acc_result_address_i [SA_LANES],
    output logic                     act_valid_o          [LANES],
    input  logic                     pool_ready_i         [LANES],
    output logic                     act_last_o           [LANES],
    output logic [DATA_WIDTH-1:0]    act_result_o         [LANES],
    output logic [ADDRESS_WIDTH-1:0] act_result_address_o [SA_LANES],
    output logic                     frame_done_o
);

    logic [LANES-1:0] set_now;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        if (gi < SA_LANES) begin : g_sa
            activation_lane #(
                .DATA_WIDTH   (DATA_WIDTH),
                .ADDRESS_WIDTH(ADDRESS_WIDTH),
                .LEAKY_SHIFT  (LEAKY_SHIFT)
            ) u_lane (
                .clk               (clk),
                .rst_n             (rst_n),
                .lane_en           (lane_en_i[gi]),
                .mode              (mode_i),
                .clip              (clip_i),
                .acc_valid         (acc_valid_i[gi]),
                .acc_ready         (acc_ready_o[gi]),
                .acc_last          (acc_last_i[gi]),
                .acc_result        (acc_result_i[gi]),
                .acc_result_address(acc_result_address_i[gi]),
                .act_valid         (act_valid_o[gi]),
                .pool_ready        (pool_ready_i[gi]),
                .act_last          (act_last_o[gi]),
                .act_result        (act_result_o[gi]),
                .act_result_address(act_result_address_o[gi])
            );
        end else begin : g_fc
            // FC lanes carry no address; the constant field is optimised away.
            logic [ADDRESS_WIDTH-1:0] fc_addr_unused;
            activation_lane #(
                .DATA_WIDTH   (DATA_WIDTH),
                .ADDRESS_WIDTH(ADDRESS_WIDTH),
                .LEAKY_SHIFT  (LEAKY_SHIFT)
            ) u_lane (
                .clk               (clk),
                .rst_n             (rst_n),
                .lane_en           (lane_en_i[gi]),
                .mode              (mode_i),
                .clip              (clip_i),
                .acc_valid         (acc_valid_i[gi]),
                .acc_ready         (acc_ready_o[gi]),
                .acc_last          (acc_last_i[gi]),
                .acc_result        (acc_result_i[gi]),
                .acc_result_address('0),
                .act_valid         (act_valid_o[gi]),
                .pool_ready        (pool_ready_i[gi]),
                .act_last          (act_last_o[gi]),
                .act_result        (act_result_o[gi]),
                .act_result_address(fc_addr_unused)
            );
        end
        assign set_now[gi] = act_valid_o[gi] && pool_ready_i[gi] && act_last_o[gi];
    end

    logic [LANES-1:0] done_vec_reg;
    logic [LANES-1:0] done_vec_next;
    logic             frame_complete;
    logic             frame_done_reg;

    always_comb begin
        done_vec_next  = done_vec_reg | set_now;
        frame_complete = (lane_en_i != '0) && ((done_vec_next & lane_en_i) == lane_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_vec_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_complete;
            done_vec_reg   <= frame_complete ? '0 : done_vec_next;
        end
    end

    assign frame_done_o = frame_done_reg;

endmodule
